// File: rtl/rbshift_pipe.sv
// Pipelined right barrel shifter: STAGES registered stages, stage k shifts by 2^k.
// Optional macro RBSHIFT_ARITH_EN adds an 'arith' port for sign-filling shifts.
module rbshift_pipe #(
   parameter int WIDTH  = 16,
   parameter int STAGES = $clog2(WIDTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  data_in,
   input  logic [STAGES-1:0] shift_amt,
`ifdef RBSHIFT_ARITH_EN
   input  logic              arith,
`endif
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  data_out,
   output logic              busy
);

   logic [STAGES-1:0] valid_q, valid_d;
   logic [STAGES-1:0] adv;
   logic [WIDTH-1:0]  data_q [STAGES];
   logic [WIDTH-1:0]  data_d [STAGES];
   // amt_q[k] holds the not-yet-applied shift bits, right-justified.
   logic [STAGES-1:0] amt_q [STAGES];
   logic [STAGES-1:0] amt_d [STAGES];
`ifdef RBSHIFT_ARITH_EN
   logic              fill_q [STAGES];
   logic              fill_d [STAGES];
`endif

   // Stage k may advance unless it and every stage after it is full and
   // the output is stalled; written without a chained self-reference.
   always_comb begin : advance_logic
      for (int k = 0; k < STAGES; k++) begin
         adv[k] = out_ready || !(&(valid_q | STAGES'((1 << k) - 1)));
      end
   end

   always_comb begin : datapath
      logic [WIDTH-1:0]  src;
      logic [STAGES-1:0] src_amt;
      logic              src_valid;
`ifdef RBSHIFT_ARITH_EN
      logic              src_fill;
`endif
      for (int k = 0; k < STAGES; k++) begin
         // NOTE: every temporary is assigned on both branches before use, so
         // no state is implied and no latch is inferred.
         if (k == 0) begin
            src       = data_in;
            src_amt   = shift_amt;
            // Only loaded when adv[0] (= in_ready) is high, so this is in_valid && in_ready.
            src_valid = in_valid;
`ifdef RBSHIFT_ARITH_EN
            src_fill  = arith & data_in[WIDTH-1];
`endif
         end else begin
            src       = data_q[(k > 0) ? k - 1 : 0];
            src_amt   = amt_q[(k > 0) ? k - 1 : 0];
            src_valid = valid_q[(k > 0) ? k - 1 : 0];
`ifdef RBSHIFT_ARITH_EN
            src_fill  = fill_q[(k > 0) ? k - 1 : 0];
`endif
         end

         data_d[k] = src;
         if (src_amt[0]) begin
`ifdef RBSHIFT_ARITH_EN
            data_d[k] = (src >> (1 << k)) |
                        ({WIDTH{src_fill}} & ~({WIDTH{1'b1}} >> (1 << k)));
`else
            data_d[k] = src >> (1 << k);
`endif
         end
         amt_d[k]   = src_amt >> 1;
         valid_d[k] = src_valid;
`ifdef RBSHIFT_ARITH_EN
         fill_d[k]  = src_fill;
`endif
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // stage samples the previous stage's pre-edge value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            data_q[k] <= '0;
            amt_q[k]  <= '0;
`ifdef RBSHIFT_ARITH_EN
            fill_q[k] <= 1'b0;
`endif
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (adv[k]) begin
               valid_q[k] <= valid_d[k];
               data_q[k]  <= data_d[k];
               amt_q[k]   <= amt_d[k];
`ifdef RBSHIFT_ARITH_EN
               fill_q[k]  <= fill_d[k];
`endif
            end
         end
      end
   end

   assign in_ready  = adv[0];
   assign out_valid = valid_q[STAGES-1];
   assign data_out  = data_q[STAGES-1];
   assign busy      = |valid_q;

endmodule

// File: tb/tb_rbshift_pipe.sv
// Directed self-checking bench for rbshift_pipe (WIDTH=16, four stages).
module tb_rbshift_pipe;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] data_in;
   logic [3:0]  shift_amt;
   logic        arith;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] data_out;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   rbshift_pipe #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_in   (data_in),
      .shift_amt (shift_amt),
`ifdef RBSHIFT_ARITH_EN
      .arith     (arith),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      in_valid = 0; out_ready = 0; data_in = '0; shift_amt = '0; arith = 0;
      #2;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (data_out !== 16'h0) begin failures++; $display("FAIL reset_data_out got %h want 0000", data_out); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      @(negedge clk);
      rst = 0;
   endtask

   // 8000 >> 0..15 streamed back to back; fixed four-cycle latency.
   task automatic test_sweep();
      logic [15:0] exp;
      logic        exp_v;
      out_ready = 1;
      for (int c = 0; c <= 20; c++) begin
         @(negedge clk);
         exp_v = (c >= 4 && c < 20);
         checks++; if (out_valid !== exp_v) begin failures++; $display("FAIL sweep_valid c=%0d got %b want %b", c, out_valid, exp_v); end
         if (exp_v) begin
            exp = 16'h8000 >> (c - 4);
            checks++; if (data_out !== exp) begin failures++; $display("FAIL sweep_data c=%0d got %h want %h", c, data_out, exp); end
         end
         checks++; if (busy !== (c >= 1 && c <= 19)) begin failures++; $display("FAIL sweep_busy c=%0d got %b", c, busy); end
         checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL sweep_in_ready c=%0d got %b want 1", c, in_ready); end
         in_valid  = (c < 16);
         data_in   = 16'h8000;
         shift_amt = c[3:0];
      end
      in_valid = 0;
   endtask

   task automatic test_values();
      logic [15:0] d_tab [5] = '{16'hF00B, 16'h00FF, 16'h1234, 16'hA5A5, 16'h8001};
      logic [3:0]  a_tab [5] = '{4'd4, 4'd2, 4'd0, 4'd1, 4'd15};
      logic [15:0] e_tab [5] = '{16'h0F00, 16'h003F, 16'h1234, 16'h52D2, 16'h0001};
      int i = 0, j = 0;
      logic acc;
      out_ready = 1;
      for (int c = 0; c < 30 && j < 5; c++) begin
         @(negedge clk);
         in_valid  = (i < 5);
         data_in   = d_tab[(i < 5) ? i : 0];
         shift_amt = a_tab[(i < 5) ? i : 0];
         #1;
         acc = in_valid && in_ready;
         if (out_valid && out_ready) begin
            checks++; if (data_out !== e_tab[j]) begin failures++; $display("FAIL values_%0d got %h want %h", j, data_out, e_tab[j]); end
            j++;
         end
         @(posedge clk);
         if (acc) i++;
      end
      in_valid = 0;
      checks++; if (j != 5) begin failures++; $display("FAIL values_count got %0d want 5", j); end
   endtask

   task automatic test_backpressure();
      int i = 0, j = 0;
      logic acc, held = 0, saw_stall = 0;
      logic [15:0] held_data = '0, exp;
      for (int c = 0; c < 40 && j < 6; c++) begin
         @(negedge clk);
         out_ready = !(c >= 5 && c <= 9);
         in_valid  = (i < 6);
         data_in   = 16'hFFFF;
         shift_amt = i[3:0];
         #1;
         if (!in_ready) saw_stall = 1;
         if (held) begin
            checks++; if (data_out !== held_data) begin failures++; $display("FAIL bp_stable c=%0d got %h want %h", c, data_out, held_data); end
         end
         held      = out_valid && !out_ready;
         held_data = data_out;
         acc = in_valid && in_ready;
         if (out_valid && out_ready) begin
            exp = 16'hFFFF >> j;
            checks++; if (data_out !== exp) begin failures++; $display("FAIL bp_data_%0d got %h want %h", j, data_out, exp); end
            j++;
         end
         @(posedge clk);
         if (acc) i++;
      end
      in_valid = 0;
      checks++; if (j != 6) begin failures++; $display("FAIL bp_count got %0d want 6", j); end
      checks++; if (saw_stall !== 1'b1) begin failures++; $display("FAIL bp_in_ready_drop got %b want 1", saw_stall); end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_extra c=%0d got %b want 0", c, out_valid); end
      end
   endtask

   // Two beats separated by a gap collapse behind a stalled output.
   task automatic test_bubble();
      out_ready = 0;
      for (int c = 0; c <= 10; c++) begin
         @(negedge clk);
         out_ready = (c >= 8);
         in_valid  = (c == 0 || c == 3);
         data_in   = (c == 0) ? 16'hC3C3 : 16'h0F0F;
         shift_amt = (c == 0) ? 4'd3 : 4'd8;
         #1;
         if (c == 3 || c == 7) begin
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bubble_in_ready c=%0d got %b want 1", c, in_ready); end
         end
         if (c == 7 || c == 8) begin
            checks++; if (out_valid !== 1'b1 || data_out !== 16'h1878) begin failures++; $display("FAIL bubble_first c=%0d got %b/%h want 1/1878", c, out_valid, data_out); end
         end
         if (c == 9) begin
            checks++; if (out_valid !== 1'b1 || data_out !== 16'h000F) begin failures++; $display("FAIL bubble_second got %b/%h want 1/000f", out_valid, data_out); end
         end
         if (c == 10) begin
            checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL bubble_drain got %b/%b want 0/0", out_valid, busy); end
         end
      end
      in_valid = 0;
   endtask

   task automatic test_reset_mid();
      logic [15:0] d_tab [3] = '{16'hFFFF, 16'hAAAA, 16'h5555};
      out_ready = 0;
      for (int c = 0; c <= 4; c++) begin
         @(negedge clk);
         in_valid  = (c < 3);
         data_in   = d_tab[(c < 3) ? c : 0];
         shift_amt = 4'd0;
      end
      checks++; if (out_valid !== 1'b1 || data_out !== 16'hFFFF) begin failures++; $display("FAIL rstmid_pre got %b/%h want 1/ffff", out_valid, data_out); end
      #2 rst = 1;
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got %b want 0", out_valid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got %b want 0", busy); end
      checks++; if (data_out !== 16'h0) begin failures++; $display("FAIL rstmid_data got %h want 0000", data_out); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got %b want 1", in_ready); end
      @(negedge clk);
      rst = 0;
      out_ready = 1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_stale c=%0d got %b/%b want 0/0", c, out_valid, busy); end
      end
   endtask

`ifdef RBSHIFT_ARITH_EN
   task automatic test_arith();
      logic [15:0] d_tab [3] = '{16'h8000, 16'h8000, 16'h4000};
      logic [3:0]  a_tab [3] = '{4'd15, 4'd15, 4'd14};
      logic        s_tab [3] = '{1'b1, 1'b0, 1'b1};
      logic [15:0] e_tab [3] = '{16'hFFFF, 16'h0001, 16'h0001};
      int i = 0, j = 0;
      logic acc;
      out_ready = 1;
      for (int c = 0; c < 30 && j < 3; c++) begin
         @(negedge clk);
         in_valid  = (i < 3);
         data_in   = d_tab[(i < 3) ? i : 0];
         shift_amt = a_tab[(i < 3) ? i : 0];
         arith     = s_tab[(i < 3) ? i : 0];
         #1;
         acc = in_valid && in_ready;
         if (out_valid && out_ready) begin
            checks++; if (data_out !== e_tab[j]) begin failures++; $display("FAIL arith_%0d got %h want %h", j, data_out, e_tab[j]); end
            j++;
         end
         @(posedge clk);
         if (acc) i++;
      end
      in_valid = 0;
      arith    = 0;
      checks++; if (j != 3) begin failures++; $display("FAIL arith_count got %0d want 3", j); end
   endtask
`endif

   initial begin
      rst = 1'b1;
      test_reset();
      test_sweep();
      test_values();
      test_backpressure();
      test_bubble();
      test_reset_mid();
`ifdef RBSHIFT_ARITH_EN
      test_arith();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rbshift_pipe.md
Name: rbshift_pipe

Overview:
- Pipelined right barrel shifter: the right-shift counterpart of the combinational left shifter (lbshift).
- Decomposes a shift of 0..WIDTH-1 into $clog2(WIDTH) registered stages; stage k shifts by 2^k when bit k of the shift amount is set.
- Valid/ready handshake on both sides, full-throughput streaming, backpressure supported.
- Used in datapaths where a single-cycle WIDTH-wide shifter misses timing.

Parameters:
- WIDTH, 16, data width; must be a power of two, >= 2.
- STAGES, $clog2(WIDTH), pipeline depth; derived, do not override.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  block can accept an input beat this cycle.
- data_in  input  WIDTH  operand.
- shift_amt  input  $clog2(WIDTH)  right-shift distance, 0..WIDTH-1.
- out_valid  output  1  result present on data_out.
- out_ready  input  1  downstream accepts the result.
- data_out  output  WIDTH  shifted result.
- busy  output  1  at least one stage holds a valid beat.

Behaviour:
- Per stage k (0..STAGES-1), registered:
  - valid_k, data_k, and the remaining shift bits amt_k[STAGES-1:k+1].
  - Stage 0 captures data_in >> (shift_amt[0] ? 1 : 0).
  - Stage k captures data_{k-1} >> (amt bit k ? 2^k : 0).
  - Vacated MSBs fill with 0 (logical shift; see Optional Feature).
- data_out = data_{STAGES-1}; out_valid = valid_{STAGES-1}.
- Advance rule:
  - adv_{STAGES-1} = !valid_{STAGES-1} || out_ready.
  - adv_k = !valid_k || adv_{k+1}.
  - in_ready = adv_0 (combinational from out_ready through the chain; no registered skid).
- Stage k loads when adv_k is high: valid_k <= valid_{k-1} (stage 0: in_valid && in_ready), and data/amt load together.
- A stage holds all of its registers when adv_k is low.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+STAGES-1. With out_ready held high, that is STAGES cycles from acceptance to consumption.
- Throughput: one beat per cycle when out_ready=1.
- Bubbles collapse: empty stages always accept, so a stalled output does not block upstream stages that still have room.
- Order preserved; no beat is dropped or duplicated.
- busy = OR of all valid_k.
- shift_amt = 0: data passes unchanged after STAGES cycles.
- shift_amt = WIDTH-1: only the original MSB survives, at bit 0.
- data_in and shift_amt are ignored when in_valid=0 or in_ready=0.
- Reset (asynchronous, any time, including mid-stream):
  - All valid_k = 0, data_k = 0, amt_k = 0; in-flight beats are discarded.
  - Outputs during reset: out_valid=0, data_out=0, busy=0, in_ready=1.
  - First acceptance is possible on the first clk edge after rst deasserts.
- out_valid=1 with out_ready=0: data_out holds stable until the handshake completes.

Optional Feature:
- Macro: RBSHIFT_ARITH_EN.
- Defined:
  - Adds input port arith (1 bit), captured with the beat and carried down the pipeline.
  - arith=1: vacated MSBs fill with the operand's original bit WIDTH-1 (arithmetic shift); the sign bit is registered in stage 0 and carried.
  - arith=0: zero fill.
- Undefined: port absent; zero fill only; no extra registers.

Test Plan:
- After reset, data_in=16'h8000, shift_amt=0..15, in_valid=1, out_ready=1 -> outputs 16'h8000, 16'h4000, ... 16'h0001 in order, first appearing 4 cycles after the first acceptance, one per cycle; busy=1 throughout.
- data_in=16'hF00B, shift_amt=4 -> 16'h0F00; data_in=16'h00FF, shift_amt=2 -> 16'h003F.
- Backpressure: stream 6 beats, out_ready=0 for cycles 5-9 -> in_ready drops once all 4 stages are full; data_out is stable while stalled; all 6 results arrive in order with no loss or duplication.
- Bubble collapse: one beat, then in_valid=0 for 2 cycles, then a second beat, while out_ready=0 -> both beats are held in adjacent stages; releasing out_ready delivers them on consecutive cycles.
- Reset mid-stream: assert rst with 3 beats in flight, asynchronously between edges -> out_valid, busy, and data_out go to 0 immediately; in_ready=1; no stale beats emerge after release.
- With RBSHIFT_ARITH_EN: data_in=16'h8000, shift_amt=15, arith=1 -> 16'hFFFF; arith=0 -> 16'h0001.
